aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- AES-128 key schedule engine.
- Accepts a 128-bit cipher key and emits round keys 0..NUM_ROUNDS, one per output handshake.
- Sits beside the byte S-box lookup and consumes it: four S-box lookups implement SubWord.
- Feeds the round datapath's AddRoundKey stage.

Parameters:
- NUM_ROUNDS, 10: index of the last round key emitted. Legal range 1..10; elaboration error outside this range.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  128  cipher key; byte 0 at [127:120].
- key_valid  input  1  key_in valid.
- key_ready  output  1  engine idle and able to accept a key.
- abort  input  1  synchronous flush to IDLE.
- rk_out  output  128  current round key; same byte order as key_in.
- rk_idx  output  4  round index of rk_out.
- rk_valid  output  1  rk_out/rk_idx valid.
- rk_ready  input  1  downstream accepts the round key.

Behaviour:
- Reset: asynchronous and active-high, clock clk (fixed). All state clears. State=IDLE, key_ready=1, rk_valid=0, rk_out=0, rk_idx=0, rcon=8'h01.
- State IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&&key_ready: rk_out<=key_in, rk_idx<=0, rcon<=8'h01, go to EMIT.
  - Latency: key accepted at edge N; rk_valid=1 during cycle N+1.
- State EMIT:
  - key_ready=0, rk_valid=1.
  - rk_out and rk_idx hold stable while rk_ready=0 (full backpressure).
  - key_valid is ignored.
- EMIT handshake with rk_idx<NUM_ROUNDS:
  - Registered next key computed from w0..w3 (w0=[127:96]).
  - temp = SubWord(RotWord(w3)) XOR {rcon,24'h0}.
  - w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - rk_idx increments; rcon<=xtime(rcon), i.e. (rcon<<1)^(rcon[7]?8'h1B:0).
- EMIT handshake with rk_idx==NUM_ROUNDS: go to IDLE. key_ready=1 the following cycle.
- Throughput: one round key per cycle while rk_ready is held high. Back-to-back keys have a mandatory one-cycle gap (IDLE).
- RotWord: bytes {b0,b1,b2,b3} become {b1,b2,b3,b0}.
- The SubWord path is combinational from the rk_out register. There is no extra pipeline stage.
- abort=1 in any state: next edge returns to IDLE; rk_valid=0; rk_out, rk_idx and rcon keep their values. abort has priority over both handshakes in the same cycle.
- An asynchronous rst mid-sequence discards the sequence immediately; no partial completion.
- rk_idx never exceeds NUM_ROUNDS; no wrap-around.

Optional Feature:
- Macro: AES_KEY_EXPAND_ZEROIZE_EN.
- Defined: on the final handshake or on abort, rk_out and all key registers clear to 0 at the next edge. In IDLE, rk_out reads 0.
- Undefined: rk_out retains the last round key in IDLE.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package aes_pkg:
  - typedefs aes_word_t (32b) and aes_block_t (128b).
  - constants RCON_INIT=8'h01 and XTIME_POLY=8'h1B.
  - function xtime.
  - state enum {IDLE, EMIT}.
- One natural sub-module, aes_key_gword: RotWord + four byte S-box instances + Rcon XOR (32b in, rcon in, 32b temp out).
- The top module holds the FSM, registers and XOR chain.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 throughout:
   - idx0 equals the key.
   - idx1 = a0fafe1788542cb123a339392a6c7605.
   - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 on 11 consecutive cycles.
   - key_ready=1 the cycle after idx10.
2. All-zero key:
   - idx1 = 62636363626363636263636362636363.
   - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Random rk_ready stalls on the FIPS key: rk_out/rk_idx stable while stalled; the sequence matches test 1 exactly; key_valid pulses during EMIT are ignored.
4. abort asserted at idx4 together with rk_ready=1: rk_valid=0 next cycle, key_ready=1. A new key then restarts at idx0 with rcon=01, and idx1 is correct.
5. rst pulsed asynchronously mid-cycle at idx6: outputs reach reset values immediately, with no clock edge needed. After release, the FIPS sequence runs cleanly.
6. ZEROIZE_EN build, FIPS key: after the idx10 handshake rk_out=0 in IDLE. Non-ZEROIZE build: rk_out holds d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types, constants and helpers for the key schedule engine.
//   aes_word_t  : 32-bit key-schedule word
//   aes_block_t : 128-bit round key / cipher key
//   RCON_INIT   : round constant for the first expansion step
//   XTIME_POLY  : GF(2^8) reduction term used by xtime
//   state_t     : key-schedule FSM states
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_block_t;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1B;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_expand_gword.sv
// -----------------------------------------------------------------------------
// aes_key_gword
// Key-schedule g-function: SubWord(RotWord(w)) XOR {rcon, 24'h0}.
//   w_in   : last word (w3) of the current round key
//   rcon   : round constant for this step
//   temp   : value folded into w0 of the next round key
// -----------------------------------------------------------------------------
module aes_key_gword
   import aes_pkg::*;
(
   input  aes_word_t   w_in,
   input  logic [7:0]  rcon,
   output aes_word_t   temp
);

   aes_word_t rot_word;
   aes_word_t sub_word;

   // {b0,b1,b2,b3} -> {b1,b2,b3,b0}
   assign rot_word = {w_in[23:0], w_in[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .a (rot_word[gi*8 +: 8]),
            .y (sub_word[gi*8 +: 8])
         );
      end
   endgenerate

   assign temp = sub_word ^ {rcon, 24'h000000};

endmodule

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (one byte in, one byte out).
//   a : input byte
//   y : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Entry 0 sits in the most significant byte, so entry k lives at
   // byte position 255-k, which for an 8-bit index is simply ~a.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// AES-128 key schedule engine. Accepts a cipher key and emits round keys
// 0..NUM_ROUNDS, one per rk_valid/rk_ready handshake.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   key_in/valid    : cipher key input (byte 0 at [127:120])
//   key_ready       : idle, able to accept a key
//   abort           : synchronous flush back to IDLE (highest priority)
//   rk_out/rk_idx   : current round key and its index
//   rk_valid/ready  : round key output handshake
//
// Build option: define AES_KEY_EXPAND_ZEROIZE_EN to clear rk_out on the final
// handshake and on abort, so no key material is left visible in IDLE.
// -----------------------------------------------------------------------------
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic         abort,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_valid,
   input  logic         rk_ready
);

   generate
      if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
         $error("aes_key_expand: NUM_ROUNDS must be in 1..10");
      end
   endgenerate

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   state_t     state_q, state_d;
   aes_block_t rk_out_q, rk_out_d;
   logic [3:0] rk_idx_q, rk_idx_d;
   logic [7:0] rcon_q, rcon_d;

   aes_word_t  w0, w1, w2, w3;
   aes_word_t  temp;
   aes_word_t  w0_n, w1_n, w2_n, w3_n;
   aes_block_t next_key;

   assign w0 = rk_out_q[127:96];
   assign w1 = rk_out_q[95:64];
   assign w2 = rk_out_q[63:32];
   assign w3 = rk_out_q[31:0];

   // The g-function works straight off the rk_out register; the next round
   // key is ready within the same cycle the current one is presented.
   aes_key_gword u_gword (
      .w_in (w3),
      .rcon (rcon_q),
      .temp (temp)
   );

   assign w0_n     = w0 ^ temp;
   assign w1_n     = w1 ^ w0_n;
   assign w2_n     = w2 ^ w1_n;
   assign w3_n     = w3 ^ w2_n;
   assign next_key = {w0_n, w1_n, w2_n, w3_n};

   always_comb begin
      state_d  = state_q;
      rk_out_d = rk_out_q;
      rk_idx_d = rk_idx_q;
      rcon_d   = rcon_q;

      if (abort) begin
         // Flush wins over both handshakes; index and rcon are left as-is.
         state_d = IDLE;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
         rk_out_d = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  rk_out_d = key_in;
                  rk_idx_d = 4'd0;
                  rcon_d   = RCON_INIT;
                  state_d  = EMIT;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  if (rk_idx_q == LAST_IDX) begin
                     state_d = IDLE;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
                     rk_out_d = '0;
`endif
                  end else begin
                     rk_out_d = next_key;
                     rk_idx_d = rk_idx_q + 4'd1;
                     rcon_d   = xtime(rcon_q);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rk_out_q <= '0;
         rk_idx_q <= 4'd0;
         rcon_q   <= RCON_INIT;
      end else begin
         state_q  <= state_d;
         rk_out_q <= rk_out_d;
         rk_idx_q <= rk_idx_d;
         rcon_q   <= rcon_d;
      end
   end

   assign key_ready = (state_q == IDLE);
   assign rk_valid  = (state_q == EMIT);
   assign rk_out    = rk_out_q;
   assign rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

   logic         clk;
   logic         rst;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         abort;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         rk_valid;
   logic         rk_ready;

   int checks;
   int failures;

   logic [127:0] fips_rk [0:10];
   logic [127:0] final_idle_rk;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_KEY = 128'h0;

   aes_key_expand #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .abort     (abort),
      .rk_out    (rk_out),
      .rk_idx    (rk_idx),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a key at a negedge; it is taken on the following posedge.
   task automatic start_key(input logic [127:0] k);
      key_in    = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      checks++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_idx !== 4'd0) begin
         failures++;
         $display("FAIL reset: key_ready=%b rk_valid=%b rk_out=%h rk_idx=%0d required 1 0 0 0",
                  key_ready, rk_valid, rk_out, rk_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("reset: key_ready=%b rk_valid=%b", key_ready, rk_valid);
   endtask

   task automatic test_fips;
      rk_ready = 1'b1;
      checks++;
      if (key_ready !== 1'b1) begin
         failures++;
         $display("FAIL fips_key_ready: got %b required 1", key_ready);
      end
      start_key(FIPS_KEY);
      for (int i = 0; i <= 10; i++) begin
         checks++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin
            failures++;
            $display("FAIL fips_rk%0d: valid=%b idx=%0d rk=%h required 1 %0d %h",
                     i, rk_valid, rk_idx, rk_out, i, fips_rk[i]);
         end
         $display("fips: idx=%0d rk=%h", rk_idx, rk_out);
         @(negedge clk);
      end
      checks++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_out !== final_idle_rk) begin
         failures++;
         $display("FAIL fips_idle: valid=%b key_ready=%b rk=%h required 0 1 %h",
                  rk_valid, key_ready, rk_out, final_idle_rk);
      end
   endtask

   task automatic test_zero_key;
      rk_ready = 1'b1;
      start_key(ZERO_KEY);
      for (int i = 0; i <= 10; i++) begin
         if (i == 1) begin
            checks++;
            if (rk_idx !== 4'd1 || rk_out !== 128'h62636363626363636263636362636363) begin
               failures++;
               $display("FAIL zero_rk1: idx=%0d rk=%h required 1 62636363626363636263636362636363",
                        rk_idx, rk_out);
            end
         end
         if (i == 10) begin
            checks++;
            if (rk_idx !== 4'd10 || rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
               failures++;
               $display("FAIL zero_rk10: idx=%0d rk=%h required 10 b4ef5bcb3e92e21123e951cf6f8f188e",
                        rk_idx, rk_out);
            end
         end
         $display("zero: idx=%0d rk=%h", rk_idx, rk_out);
         @(negedge clk);
      end
      checks++;
      if (key_ready !== 1'b1) begin
         failures++;
         $display("FAIL zero_idle: key_ready=%b required 1", key_ready);
      end
   endtask

   task automatic test_stall;
      int  cnt;
      int  cycles;
      logic r;
      cnt    = 0;
      cycles = 0;
      start_key(FIPS_KEY);
      while (cnt <= 10 && cycles < 300) begin
         checks++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(cnt) || rk_out !== fips_rk[cnt]) begin
            failures++;
            $display("FAIL stall_rk%0d: valid=%b idx=%0d rk=%h required 1 %0d %h",
                     cnt, rk_valid, rk_idx, rk_out, cnt, fips_rk[cnt]);
         end
         r         = 1'($urandom_range(0, 1));
         rk_ready  = r;
         key_in    = 128'hdeadbeef_00112233_44556677_8899aabb;
         key_valid = (cnt < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
         $display("stall: idx=%0d ready=%b key_valid=%b", rk_idx, r, key_valid);
         @(negedge clk);
         key_valid = 1'b0;
         if (r) cnt++;
         cycles++;
      end
      checks++;
      if (cnt != 11 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_end: handshakes=%0d valid=%b key_ready=%b required 11 0 1",
                  cnt, rk_valid, key_ready);
      end
      rk_ready = 1'b1;
   endtask

   task automatic test_abort;
      logic [127:0] exp_rk;
      rk_ready = 1'b1;
      start_key(FIPS_KEY);
      repeat (4) @(negedge clk);
      checks++;
      if (rk_idx !== 4'd4 || rk_out !== fips_rk[4]) begin
         failures++;
         $display("FAIL abort_pre: idx=%0d rk=%h required 4 %h", rk_idx, rk_out, fips_rk[4]);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      exp_rk = 128'h0;
`else
      exp_rk = fips_rk[4];
`endif
      checks++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_idx !== 4'd4 || rk_out !== exp_rk) begin
         failures++;
         $display("FAIL abort_post: valid=%b key_ready=%b idx=%0d rk=%h required 0 1 4 %h",
                  rk_valid, key_ready, rk_idx, rk_out, exp_rk);
      end
      $display("abort: valid=%b idx=%0d rk=%h", rk_valid, rk_idx, rk_out);
      start_key(ZERO_KEY);
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
         failures++;
         $display("FAIL abort_restart0: valid=%b idx=%0d rk=%h required 1 0 0", rk_valid, rk_idx, rk_out);
      end
      @(negedge clk);
      checks++;
      if (rk_idx !== 4'd1 || rk_out !== 128'h62636363626363636263636362636363) begin
         failures++;
         $display("FAIL abort_restart1: idx=%0d rk=%h required 1 62636363626363636263636362636363",
                  rk_idx, rk_out);
      end
      $display("abort restart: idx=%0d rk=%h", rk_idx, rk_out);
      for (int i = 0; i < 40 && rk_valid === 1'b1; i++) @(negedge clk);
      checks++;
      if (key_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_drain: key_ready=%b required 1", key_ready);
      end
   endtask

   task automatic test_async_rst;
      rk_ready = 1'b1;
      start_key(FIPS_KEY);
      repeat (6) @(negedge clk);
      checks++;
      if (rk_idx !== 4'd6 || rk_out !== fips_rk[6]) begin
         failures++;
         $display("FAIL rst_pre: idx=%0d rk=%h required 6 %h", rk_idx, rk_out, fips_rk[6]);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
         failures++;
         $display("FAIL rst_async: valid=%b key_ready=%b idx=%0d rk=%h required 0 1 0 0",
                  rk_valid, key_ready, rk_idx, rk_out);
      end
      $display("async rst: valid=%b idx=%0d rk=%h", rk_valid, rk_idx, rk_out);
      #1 rst = 1'b0;
      @(negedge clk);
      test_fips();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      key_in    = '0;
      key_valid = 1'b0;
      abort     = 1'b0;
      rk_ready  = 1'b0;

      fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      final_idle_rk = 128'h0;
`else
      final_idle_rk = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

      test_reset();
      test_fips();
      @(negedge clk);
      test_zero_key();
      @(negedge clk);
      test_stall();
      @(negedge clk);
      test_abort();
      @(negedge clk);
      test_async_rst();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
